// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between control and the alu_seq datapath.
// master = control/testbench side, slave = the ALU.
`timescale 1ns/1ps
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [3:0]       op;
    logic             assertE;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] resultHi;
    logic             busy;
    logic             done;
    logic             flagC;
    logic             flagZ;
    logic             flagN;
    logic             flagV;
    logic             aIsZero;

    modport master (
        output start, op, assertE, a, b,
        input  result, resultHi, busy, done, flagC, flagZ, flagN, flagV, aIsZero
    );

    modport slave (
        input  start, op, assertE, a, b,
        output result, resultHi, busy, done, flagC, flagZ, flagN, flagV, aIsZero
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU (add/sub/carry ops, logic, shifts) with a C/Z/N/V flag register.
// Define ALU_MUL_EN to build op 9 as a multi-cycle shift-and-add multiplier behind start/busy/done.
`timescale 1ns/1ps
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    logic [WIDTH-1:0] res_q, hi_q;
    logic             done_q;
    logic             flag_c, flag_z, flag_n, flag_v;

    // Single-cycle datapath; sum_w is WIDTH+1 wide so bit WIDTH is carry (add) or borrow (sub).
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_wr, sc_z, sc_n;
    logic             sc_go;

    always_comb begin
        sum_w  = '0;
        sc_res = bus.a;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_wr  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
                sc_res = sum_w[MSB:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = (bus.a[MSB] == bus.b[MSB]) && (sc_res[MSB] != bus.a[MSB]);
                sc_wr  = 1'b1;
            end
            OP_ADC: begin
                sum_w  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, flag_c};
                sc_res = sum_w[MSB:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = (bus.a[MSB] == bus.b[MSB]) && (sc_res[MSB] != bus.a[MSB]);
                sc_wr  = 1'b1;
            end
            OP_SUB: begin
                sum_w  = {1'b0, bus.a} - {1'b0, bus.b};
                sc_res = sum_w[MSB:0];
                sc_c   = ~sum_w[WIDTH];
                sc_v   = (bus.a[MSB] != bus.b[MSB]) && (sc_res[MSB] != bus.a[MSB]);
                sc_wr  = 1'b1;
            end
            OP_SBC: begin
                sum_w  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, ~flag_c};
                sc_res = sum_w[MSB:0];
                sc_c   = ~sum_w[WIDTH];
                sc_v   = (bus.a[MSB] != bus.b[MSB]) && (sc_res[MSB] != bus.a[MSB]);
                sc_wr  = 1'b1;
            end
            OP_AND: begin
                sc_res = bus.a & bus.b;
                sc_wr  = 1'b1;
            end
            OP_OR: begin
                sc_res = bus.a | bus.b;
                sc_wr  = 1'b1;
            end
            OP_XOR: begin
                sc_res = bus.a ^ bus.b;
                sc_wr  = 1'b1;
            end
            OP_SHL: begin
                sc_res = {bus.a[MSB-1:0], 1'b0};
                sc_c   = bus.a[MSB];
                sc_wr  = 1'b1;
            end
            OP_SHR: begin
                sc_res = {1'b0, bus.a[MSB:1]};
                sc_c   = bus.a[0];
                sc_wr  = 1'b1;
            end
            // With the multiplier built this path never completes op 9; without it, op 9 yields 0.
            OP_MUL: begin
                sc_res = '0;
            end
            default: begin
                sc_res = bus.a;
            end
        endcase
        sc_z = (sc_res == '0);
        sc_n = sc_res[MSB];
    end

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state, state_nxt;

    logic [2*WIDTH-1:0] prod, mcand, prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               mul_we;
    logic               accept, mul_start, mul_last;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mul_start = 1'b0;
        mul_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (cnt == LAST) begin
                    mul_last  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One multiplier bit per cycle, LSB first; mcand is pre-shifted to line up with that bit.
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            mul_we <= 1'b0;
        end else if (mul_start) begin
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.b};
            mplier <= bus.a;
            cnt    <= '0;
            mul_we <= bus.assertE;
        end else if (state == S_MUL) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign sc_go    = accept && !mul_start;
    assign bus.busy = (state == S_MUL);
`else
    assign sc_go    = bus.start;
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q  <= '0;
            hi_q   <= '0;
            done_q <= 1'b0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (sc_go) begin
                res_q  <= sc_res;
                hi_q   <= '0;
                done_q <= 1'b1;
                if (bus.assertE && sc_wr) begin
                    flag_c <= sc_c;
                    flag_z <= sc_z;
                    flag_n <= sc_n;
                    flag_v <= sc_v;
                end
            end
`ifdef ALU_MUL_EN
            if (mul_last) begin
                res_q  <= prod_nxt[MSB:0];
                hi_q   <= prod_nxt[2*WIDTH-1:WIDTH];
                done_q <= 1'b1;
                if (mul_we) begin
                    flag_c <= |prod_nxt[2*WIDTH-1:WIDTH];
                    flag_z <= (prod_nxt == '0);
                    flag_n <= prod_nxt[2*WIDTH-1];
                    flag_v <= 1'b0;
                end
            end
`endif
        end
    end

    assign bus.result   = res_q;
    assign bus.resultHi = hi_q;
    assign bus.done     = done_q;
    assign bus.flagC    = flag_c;
    assign bus.flagZ    = flag_z;
    assign bus.flagN    = flag_n;
    assign bus.flagV    = flag_v;
    assign bus.aIsZero  = (bus.a == '0);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed literal checks plus randomized traffic compared every cycle against an
// arithmetic reference model of the 8-bit ALU (multiplier behaviour follows ALU_MUL_EN).
`timescale 1ns/1ps
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8)) bus ();
    alu_seq #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] flags();
        return {bus.flagC, bus.flagZ, bus.flagN, bus.flagV};
    endfunction

    // Reference ALU from the arithmetic definitions, using plain integers.
    function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                    output int r, output int c, output int v, output int wr);
        int sa, sb, s;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = a; c = 0; v = 0; wr = 0;
        case (op)
            0: begin s = a + b; r = s % 256; c = int'(s > 255); s = sa + sb;
                     v = int'(s > 127 || s < -128); wr = 1; end
            1: begin r = (a - b + 256) % 256; c = int'(a >= b); s = sa - sb;
                     v = int'(s > 127 || s < -128); wr = 1; end
            2: begin s = a + b + cin; r = s % 256; c = int'(s > 255); s = sa + sb + cin;
                     v = int'(s > 127 || s < -128); wr = 1; end
            3: begin r = (a - b - (1 - cin) + 512) % 256; c = int'(a >= b + 1 - cin);
                     s = sa - sb - (1 - cin); v = int'(s > 127 || s < -128); wr = 1; end
            4: begin r = a & b; wr = 1; end
            5: begin r = a | b; wr = 1; end
            6: begin r = a ^ b; wr = 1; end
            7: begin r = (a * 2) % 256; c = int'(a >= 128); wr = 1; end
            8: begin r = a / 2; c = a % 2; wr = 1; end
            9: begin r = 0; end
            default: r = a;
        endcase
    endfunction

    logic [7:0] m_res, m_hi;
    logic       m_busy, m_done, m_c, m_z, m_n, m_v, m_we;
    int         m_cnt, m_prod;

    always @(posedge clk) begin : model
        int r, c, v, wr;
        if (reset) begin
            m_res <= 0; m_hi <= 0; m_busy <= 0; m_done <= 0;
            m_c <= 0; m_z <= 0; m_n <= 0; m_v <= 0; m_cnt <= 0; m_prod <= 0; m_we <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= 8'(m_prod % 256);
                    m_hi   <= 8'(m_prod / 256);
                    if (m_we) begin
                        m_c <= (m_prod / 256) != 0;
                        m_z <= m_prod == 0;
                        m_n <= m_prod >= 32768;
                        m_v <= 1'b0;
                    end
                end
                m_cnt <= m_cnt - 1;
            end else if (bus.start) begin
`ifdef ALU_MUL_EN
                if (bus.op == 4'd9) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 8;
                    m_prod <= int'(bus.a) * int'(bus.b);
                    m_we   <= bus.assertE;
                end else
`endif
                begin
                    ref_alu(int'(bus.op), int'(bus.a), int'(bus.b), int'(m_c), r, c, v, wr);
                    m_res  <= 8'(r);
                    m_hi   <= 8'd0;
                    m_done <= 1'b1;
                    if (bus.assertE && wr == 1) begin
                        m_c <= c[0];
                        m_z <= (r == 0);
                        m_n <= (r >= 128);
                        m_v <= v[0];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle",
                  {9'd0, bus.result, bus.resultHi, bus.busy, bus.done, flags(), bus.aIsZero},
                  {9'd0, m_res, m_hi, m_busy, m_done, m_c, m_z, m_n, m_v, bus.a == 8'd0});
    end

    task automatic go(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic e);
        bus.op = op; bus.a = a; bus.b = b; bus.assertE = e; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    int n, ndone;

    initial begin
        reset = 1'b1; bus.start = 0; bus.op = 0; bus.assertE = 0; bus.a = 8'h00; bus.b = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_out", {bus.result, bus.resultHi, bus.busy, bus.done, flags()}, 32'd0);
        check("reset_aiszero", bus.aIsZero, 1);
        reset = 1'b0;
        chk_en = 1'b1;

        go(4'd0, 8'hF0, 8'h20, 1'b1);
        check("add_done", bus.done, 1);
        check("add_res", bus.result, 8'h10);
        check("add_flags", flags(), 4'b1000);

        go(4'd1, 8'h05, 8'h07, 1'b1);
        check("sub_res", bus.result, 8'hFE);
        check("sub_flags", flags(), 4'b0010);
        go(4'd1, 8'h07, 8'h07, 1'b1);
        check("subz_res", bus.result, 8'h00);
        check("subz_flags", flags(), 4'b1100);

        go(4'd2, 8'h7E, 8'h01, 1'b1);
        check("adc_res", bus.result, 8'h80);
        check("adc_flags", flags(), 4'b0011);
        go(4'd0, 8'h01, 8'h01, 1'b0);
        check("hold_res", bus.result, 8'h02);
        check("hold_flags", flags(), 4'b0011);

        // MUL 0xFF*0xFF with an ADD start (and new operands) thrown in while busy.
        go(4'd9, 8'hFF, 8'hFF, 1'b1);
        n = 0;
        while (!bus.done && n < 20) begin
            if (n == 0) check("mul_busy", bus.busy, 1);
            if (n == 2) begin bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h01; bus.start = 1'b1; end
            if (n == 3) bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("mul_busy_end", bus.busy, 0);
`ifdef ALU_MUL_EN
        check("mul_latency", n, 8);
        check("mul_res", {bus.resultHi, bus.result}, 16'hFE01);
        check("mul_flags", flags(), 4'b1010);
`else
        check("mul_latency", n, 0);
        check("mul_res", {bus.resultHi, bus.result}, 16'h0000);
        check("mul_flags", flags(), 4'b0011);
`endif
        @(posedge clk); #1;
        check("mul_no_extra_done", bus.done, 0);

        go(4'd9, 8'h10, 8'h10, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_mul", {bus.result, bus.resultHi, bus.busy, bus.done, flags()}, 32'd0);
        ndone = 0;
        repeat (12) begin @(posedge clk); #1; if (bus.done) ndone++; end
        check("rst_no_done", ndone, 0);

        go(4'd0, 8'hFF, 8'h01, 1'b1);
        check("pre_mul_flags", flags(), 4'b1100);
        go(4'd9, 8'h03, 8'h04, 1'b1);
        n = 0;
        while (!bus.done && n < 20) begin @(posedge clk); #1; n++; end
`ifdef ALU_MUL_EN
        check("mul34_latency", n, 8);
        check("mul34_res", {bus.resultHi, bus.result}, 16'h000C);
        check("mul34_flags", flags(), 4'b0000);
`else
        check("mul34_latency", n, 0);
        check("mul34_res", {bus.resultHi, bus.result}, 16'h0000);
        check("mul34_flags", flags(), 4'b1100);
`endif

        // Random traffic: starts on most cycles (including while busy), rare resets.
        for (int i = 0; i < 600; i++) begin
            bus.start   = ($urandom_range(0, 2) != 0);
            bus.op      = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            bus.a       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.b       = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            bus.assertE = ($urandom_range(0, 3) != 0);
            reset       = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; bus.start = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
